// File: rtl/sha512_msg_feeder.sv
// sha512_msg_feeder: packs a byte stream into padded 1024-bit SHA-512 blocks and sequences init/next pulses against the core's ready flag
module sha512_msg_feeder #(
    parameter int LEN_W = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [7:0]    in_byte,
    input  logic          in_valid,
    input  logic          in_last,
    output logic          in_ready,
    output logic          sha_init,
    output logic          sha_next,
    output logic [1023:0] sha_block,
    input  logic          sha_ready,
    output logic          busy,
    output logic          done,
    output logic          err
);
    typedef enum logic [2:0] {IDLE, FILL, PAD, ISSUE, WAIT, TAIL, DONE} state_t;
    state_t          state_q, state_d;
    logic [1023:0]   blk_q, blk_d;
    logic [7:0]      n_q, n_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic            first_q, first_d, final_q, final_d, tail_q, tail_d;
    logic            pend_q, pend_d, wait1_q, wait1_d, err_q, err_d;
    logic [127:0]    len_field;
    logic [9:0]      pos;
    logic [7:0]      n_inc;
    assign len_field = {{(125-LEN_W){1'b0}}, len_q, 3'b000};
    assign pos       = 10'd1016 - {n_q[6:0], 3'b000};
    assign n_inc     = n_q + 8'd1;
    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        n_d     = n_q;
        len_d   = len_q;
        first_d = first_q;
        final_d = final_q;
        tail_d  = tail_q;
        pend_d  = pend_q;
        wait1_d = wait1_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (start) begin
                blk_d   = '0;
                n_d     = '0;
                len_d   = '0;
                first_d = 1'b1;
                final_d = 1'b0;
                tail_d  = 1'b0;
                pend_d  = 1'b0;
                err_d   = 1'b0;
                state_d = FILL;
            end
            FILL: if (in_valid) begin
                if (&len_q) err_d = 1'b1;
                else begin
                    blk_d[pos +: 8] = in_byte;
                    n_d   = n_inc;
                    len_d = len_q + 1'b1;
                end
                if (!(&len_q) && n_inc[7]) begin
                    pend_d  = in_last;
                    state_d = ISSUE;
                end else if (in_last) state_d = PAD;
            end
            PAD: begin
                blk_d[pos +: 8] = 8'h80;
                if (n_q <= 8'd111) begin
                    blk_d[127:0] = len_field;
                    final_d = 1'b1;
                end else tail_d = 1'b1;
                state_d = ISSUE;
            end
            ISSUE: begin
                first_d = 1'b0;
                wait1_d = 1'b1;
                state_d = WAIT;
            end
            WAIT: if (wait1_q) wait1_d = 1'b0;
            else if (sha_ready) begin
                if (final_q) state_d = DONE;
                else if (tail_q) begin
                    tail_d  = 1'b0;
                    state_d = TAIL;
                end else begin
                    blk_d   = '0;
                    n_d     = '0;
                    pend_d  = 1'b0;
                    state_d = pend_q ? PAD : FILL;
                end
            end
            TAIL: begin
                blk_d   = {896'd0, len_field};
                final_d = 1'b1;
                state_d = ISSUE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            blk_q   <= '0;
            n_q     <= '0;
            len_q   <= '0;
            first_q <= 1'b0;
            final_q <= 1'b0;
            tail_q  <= 1'b0;
            pend_q  <= 1'b0;
            wait1_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            n_q     <= n_d;
            len_q   <= len_d;
            first_q <= first_d;
            final_q <= final_d;
            tail_q  <= tail_d;
            pend_q  <= pend_d;
            wait1_q <= wait1_d;
            err_q   <= err_d;
        end
    end
    assign in_ready  = state_q == FILL;
    assign sha_init  = state_q == ISSUE && first_q;
    assign sha_next  = state_q == ISSUE && !first_q;
    assign sha_block = blk_q;
    assign busy      = state_q != IDLE;
    assign done      = state_q == DONE;
    assign err       = err_q;
endmodule

// File: doc/sha512_msg_feeder.md
# sha512_msg_feeder

Upstream feeder for the SHA-512 core in the encapsulation hash path. It accepts a byte stream, packs it big-endian into 1024-bit message blocks, and appends FIPS 180-4 padding with a 128-bit bit-length. It sequences `init`/`next` pulses against the core's `ready` flag. The hash-generation controller feeds it serialized polynomial bytes instead of pre-building whole padded vectors.

## Interface

Parameters:
- LEN_W, 16: width of the message byte counter; max message length is 2^LEN_W−1 bytes.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a new message. Ignored unless the FSM is in IDLE.
- in_byte  in  8  message byte.
- in_valid  in  1  in_byte is valid.
- in_last  in  1  qualifies in_byte as the final message byte.
- in_ready  out  1  feeder accepts a byte this cycle.
- sha_init  out  1  one-cycle pulse to the core for the first block.
- sha_next  out  1  one-cycle pulse to the core for each subsequent block.
- sha_block  out  1024  current block; byte 0 occupies [1023:1016].
- sha_ready  in  1  core ready flag.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse when the final block has been absorbed by the core.
- err  out  1  sticky length overflow; cleared by the next accepted start.

## Operation

- States: IDLE, FILL, PAD, ISSUE, WAIT, TAIL, DONE.
- A byte is accepted when in_valid && in_ready.
- in_ready is 1 only in FILL.
- IDLE, on start:
  - clear the block register, byte index n (0..128), total count L and first-block flag;
  - go to FILL.
- FILL, on each accepted byte:
  - write the byte at position n, n++, L++;
  - if n reaches 128, go to ISSUE (in_last is remembered as pending_pad);
  - else if in_last, go to PAD.
- PAD appends the padding in one cycle:
  - write 0x80 at position n;
  - if n ≤ 111, write L×8 (128-bit, zero-extended) into bytes 112..127 and set final=1;
  - else (112 ≤ n ≤ 127) set tail_pending=1.
  - Then go to ISSUE.
- ISSUE pulses sha_init if this is the first block, else sha_next, for exactly one cycle, then goes to WAIT.
- WAIT:
  - sha_ready is ignored on the first WAIT cycle, because the core drops ready one cycle after a pulse.
  - After that, the FSM waits for sha_ready=1, then:
    - final=1 → DONE;
    - tail_pending → TAIL;
    - pending_pad → clear the block and go to PAD with n=0 (0x80 at byte 0, length in bytes 112..127);
    - otherwise clear the block, set n=0, and return to FILL.
- TAIL loads an all-zero block with L×8 in bytes 112..127, sets final=1, and goes to ISSUE.
- DONE pulses done for 1 cycle, then returns to IDLE.
- busy = (state ≠ IDLE).
- Overflow: a byte accepted while L = 2^LEN_W−1 sets err. That byte is dropped, and n and L are unchanged. in_last still triggers PAD.
- A zero-length message is not supported; every message carries at least one byte with in_last.
- sha_block holds stable from the ISSUE cycle until sha_ready returns.
- Reset mid-operation forces IDLE immediately, clears all state, and drops any pulse in progress.

## Timing

- Reset values: in_ready=0, sha_init=0, sha_next=0, sha_block=0, busy=0, done=0, err=0.
- A start accepted at edge t gives in_ready=1 from cycle t+1.
- One byte per cycle is the maximum throughput; 128 bytes take 128 cycles.
- Last byte accepted at edge t: PAD at t+1, sha_init/sha_next high during t+2.
- Full block accepted at t: pulse high during t+1.
- done is asserted exactly 1 cycle after the WAIT cycle that samples sha_ready=1 for the final block. The core digest is valid when done is seen.
- Blocks per message: ceil((L+17)/128).

## Test plan

- "abc" (0x61,0x62,0x63, last on 0x63) → one sha_init:
  - block = 0x61626380 followed by zeros, bytes 112..127 = 0x…18;
  - core digest begins 0xddaf35a1…, done 1 pulse, no sha_next.
- 111-byte message → exactly one block with 0x80 at byte 111 and length 0x378.
- 112-byte message → two blocks:
  - block 1 has 0x80 at byte 112 and no length;
  - block 2 is zeros + length 0x380, issued via TAIL with sha_next.
- 128-byte message (last on byte 127) → block 1 is pure data; block 2 is 0x80 at byte 0 + length 0x400.
- Core model holding sha_ready low for 40 cycles:
  - in_ready stays 0 and sha_block is stable throughout;
  - no second pulse;
  - the 129th byte is accepted only after ready returns.
- LEN_W=4, 16-byte message:
  - 16th byte dropped, err=1;
  - length field 0x78;
  - reset_n low during WAIT → all outputs 0 at once;
  - a new start then works normally with err cleared.
